// File: rtl/mem_stage.sv
// Memory stage: issues data-memory requests for loads/stores, formats load data,
// and hands results to writeback through a registered output stage.
module mem_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] opr_res_i,
  input  logic [DATA_WIDTH-1:0] opr_b_i,
  input  logic [4:0]            rd_i,
  input  logic                  rf_en_i,
  input  logic                  dm_en_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [3:0]            lsuop_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [4:0]            rd_o,
  output logic                  rf_en_o,
  output logic [1:0]            wb_sel_o,
  output logic [DATA_WIDTH-1:0] opr_res_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misalign_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t r_state, w_state_next;

  logic                  w_mem, w_store, w_unsigned, w_mis;
  logic [1:0]            w_size, w_off;
  logic                  w_done, w_load_done, w_sign;
  logic [DATA_WIDTH-1:0] w_shift, w_load_data;

  logic                  r_wb_valid, r_rf_en, r_misalign;
  logic [4:0]            r_rd;
  logic [1:0]            r_wb_sel;
  logic [DATA_WIDTH-1:0] r_opr_res, r_load_data;

  assign w_mem      = valid_i & dm_en_i;
  assign w_store    = lsuop_i[3];
  assign w_unsigned = lsuop_i[2];
  assign w_size     = lsuop_i[1:0];
  assign w_off      = opr_res_i[1:0];

  // Size code 11 has no defined width, so it is rejected like a misaligned access.
  always_comb begin
    w_mis = 1'b0;
    case (w_size)
      SZ_BYTE: w_mis = 1'b0;
      SZ_HALF: w_mis = w_off[0];
      SZ_WORD: w_mis = (w_off != 2'b00);
      default: w_mis = 1'b1;
    endcase
  end

  // Request payload is derived straight from the inputs, which upstream holds while stalled.
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = opr_b_i;
    case (w_size)
      SZ_BYTE: begin
        dmem_be_o    = 4'(4'b0001 << w_off);
        dmem_wdata_o = {BE_W{opr_b_i[7:0]}};
      end
      SZ_HALF: begin
        dmem_be_o    = 4'(4'b0011 << w_off);
        dmem_wdata_o = {(BE_W/2){opr_b_i[15:0]}};
      end
      SZ_WORD: dmem_be_o = 4'b1111;
      default: dmem_be_o = 4'b0000;
    endcase
  end

  assign dmem_addr_o = {opr_res_i[DATA_WIDTH-1:2], 2'b00};
  assign dmem_we_o   = dmem_req_o & w_store;

  // Load alignment and extension.
  always_comb begin
    w_shift     = dmem_rdata_i >> {w_off, 3'b000};
    w_sign      = 1'b0;
    w_load_data = w_shift;
    case (w_size)
      SZ_BYTE: begin
        w_sign      = ~w_unsigned & w_shift[7];
        w_load_data = {{(DATA_WIDTH-8){w_sign}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        w_sign      = ~w_unsigned & w_shift[15];
        w_load_data = {{(DATA_WIDTH-16){w_sign}}, w_shift[15:0]};
      end
      default: w_load_data = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, request/stall handshake and completion strobes.
  always_comb begin
    w_state_next = r_state;
    dmem_req_o   = 1'b0;
    stall_o      = 1'b0;
    w_done       = 1'b0;
    w_load_done  = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_mem && w_mis) begin
            w_done = 1'b1;
          end else if (w_mem) begin
            dmem_req_o = 1'b1;
            if (dmem_gnt_i && w_store) begin
              w_done = 1'b1;
            end else if (dmem_gnt_i) begin
              stall_o      = 1'b1;
              w_state_next = WAIT;
            end else begin
              stall_o      = 1'b1;
              w_state_next = REQ;
            end
          end else if (valid_i) begin
            w_done = 1'b1;
          end
        end
        REQ: begin
          dmem_req_o = 1'b1;
          stall_o    = 1'b1;
          if (dmem_gnt_i && w_store) begin
            stall_o      = 1'b0;
            w_done       = 1'b1;
            w_state_next = IDLE;
          end else if (dmem_gnt_i) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          stall_o = 1'b1;
          if (dmem_rvalid_i) begin
            stall_o      = 1'b0;
            w_done       = 1'b1;
            w_load_done  = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Writeback register: captured on completion, otherwise held with valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_rd        <= '0;
      r_rf_en     <= 1'b0;
      r_wb_sel    <= '0;
      r_opr_res   <= '0;
      r_load_data <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_wb_valid <= w_done;
      if (w_done) begin
        r_rd        <= rd_i;
        r_rf_en     <= rf_en_i & ~(w_mem & (w_store | w_mis));
        r_wb_sel    <= wb_sel_i;
        r_opr_res   <= opr_res_i;
        r_load_data <= w_load_done ? w_load_data : '0;
        r_misalign  <= w_mem & w_mis;
      end
    end
  end

  assign wb_valid_o  = r_wb_valid;
  assign rd_o        = r_rd;
  assign rf_en_o     = r_rf_en;
  assign wb_sel_o    = r_wb_sel;
  assign opr_res_o   = r_opr_res;
  assign load_data_o = r_load_data;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops checked against
// an arithmetic reference model of the load/store rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, rf_en_i, dm_en_i;
  logic [31:0] opr_res_i, opr_b_i;
  logic [4:0]  rd_i;
  logic [1:0]  wb_sel_i;
  logic [3:0]  lsuop_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, rf_en_o, misalign_o;
  logic [4:0]  rd_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] opr_res_o, load_data_o;

  int errors = 0;
  int checks = 0;

  mem_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opr_res_i(opr_res_i), .opr_b_i(opr_b_i),
    .rd_i(rd_i), .rf_en_i(rf_en_i), .dm_en_i(dm_en_i), .wb_sel_i(wb_sel_i), .lsuop_i(lsuop_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .rd_o(rd_o), .rf_en_o(rf_en_o), .wb_sel_o(wb_sel_o),
    .opr_res_o(opr_res_o), .load_data_o(load_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] op, input int off, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * off);
    if (op[1:0] == 2'd0) begin
      v = v % 256;
      if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op[1:0] == 2'd1) begin
      v = v % 65536;
      if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One op: gd = cycles until grant, rvd = cycles from grant to rvalid.
  task automatic run_op(input logic v, input logic dm, input logic [3:0] op,
                        input logic [31:0] res, input logic [31:0] opb,
                        input logic [4:0] rd, input logic rfe, input logic [1:0] sel,
                        input int gd, input int rvd, input logic [31:0] rdata);
    int off, size, done_c;
    logic mem, store, mis, issue;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
    off   = int'(res % 4);
    size  = int'(op[1:0]);
    mem   = v && dm;
    store = op[3];
    mis   = (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    issue = mem && !mis;
    done_c = !issue ? 0 : (store ? gd : gd + rvd);
    exp_be = (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'd15;
    exp_wd = (size == 0) ? (opb % 256) * 32'h0101_0101 :
             (size == 1) ? (opb % 65536) * 32'h0001_0001 : opb;
    @(negedge clk);
    valid_i = v; dm_en_i = dm; lsuop_i = op; opr_res_i = res; opr_b_i = opb;
    rd_i = rd; rf_en_i = rfe; wb_sel_i = sel;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt_i    = issue && (c == gd);
      dmem_rvalid_i = (c <= gd) ? 1'($urandom % 2) : (c == done_c && issue && !store);
      dmem_rdata_i  = (c == done_c) ? rdata : $urandom;
      #1;
      check("stall", stall_o, v && (c != done_c));
      check("req", dmem_req_o, issue && c <= gd);
      if (issue && c <= gd) begin
        check("addr", dmem_addr_o, res - off);
        check("be", dmem_be_o, exp_be);
        check("wdata", dmem_wdata_o, exp_wd);
        check("we", dmem_we_o, store);
      end
      @(posedge clk); #1;
      if (c == done_c) begin
        check("wb_valid", wb_valid_o, v);
        if (v) begin
          check("rd", rd_o, rd);
          check("rf_en", rf_en_o, rfe && !(mem && (store || mis)));
          check("wb_sel", wb_sel_o, sel);
          check("opr_res", opr_res_o, res);
          check("misalign", misalign_o, mem && mis);
          if (issue && !store) check("load_data", load_data_o, ref_load(op, off, rdata));
        end
      end else begin
        check("wb_valid_hold", wb_valid_o, 1'b0);
      end
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b1; dm_en_i = 1'b1; lsuop_i = 4'b0010; opr_res_i = 32'h100; opr_b_i = '0;
    rd_i = '0; rf_en_i = 1'b1; wb_sel_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_opr_res", opr_res_o, 32'h0);
    check("rst_rf_en", rf_en_o, 1'b0);
    valid_i = 1'b0; dm_en_i = 1'b0;
    rst = 1'b0;

    // ADD, SB, LH, LBU, LW-misaligned
    run_op(1, 0, 4'b0000, 32'h0000_1234, 32'h0, 5'd5, 1, 2'd0, 0, 0, 32'h0);
    run_op(1, 1, 4'b1000, 32'h0000_0103, 32'hAB, 5'd0, 0, 2'd1, 0, 0, 32'h0);
    run_op(1, 1, 4'b0001, 32'h0000_0202, 32'h0, 5'd7, 1, 2'd1, 2, 3, 32'h8001_0000);
    run_op(1, 1, 4'b0100, 32'h0000_0301, 32'h0, 5'd8, 1, 2'd1, 0, 1, 32'h0000_F000);
    run_op(1, 1, 4'b0010, 32'h0000_0402, 32'h0, 5'd9, 1, 2'd1, 0, 0, 32'h0);
    run_op(1, 1, 4'b0011, 32'h0000_0500, 32'h0, 5'd10, 1, 2'd1, 0, 0, 32'h0);

    // Reset during WAIT abandons the load; a stray rvalid afterwards is ignored.
    @(negedge clk);
    valid_i = 1'b1; dm_en_i = 1'b1; lsuop_i = 4'b0010; opr_res_i = 32'h600; rd_i = 5'd3; rf_en_i = 1'b1;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    check("wait_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rstw_stall", stall_o, 1'b0);
    check("rstw_req", dmem_req_o, 1'b0);
    check("rstw_opr_res", opr_res_o, 32'h0);
    check("rstw_rd", rd_o, 5'd0);
    check("rstw_wb_valid", wb_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0; dm_en_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("stray_wb_valid", wb_valid_o, 1'b0);
    check("stray_stall", stall_o, 1'b0);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    @(posedge clk); #1;
    check("stray_wb_valid2", wb_valid_o, 1'b0);

    for (int n = 0; n < 80; n++) begin
      run_op(1'($urandom % 8 != 0), 1'($urandom % 4 != 0), 4'($urandom), $urandom, $urandom,
             5'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 3)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
